// File: rtl/jmpz_pkg.sv
// ============================================================================
// Package : jmpz_pkg
// Brief   : Shared defaults and types for the JMPZ program-flow block.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package jmpz_pkg;

  localparam int DEFAULT_ADDR_W = 20;
  localparam int DEFAULT_CNT_W  = 16;

  typedef logic [DEFAULT_ADDR_W-1:0] addr_t;

  localparam addr_t DEFAULT_RESET_PC = 20'h00000;
  localparam addr_t DEFAULT_PC_STEP  = 20'h00001;

endpackage : jmpz_pkg

`default_nettype wire

// File: rtl/jmpz_pc_unit_if.sv
// ============================================================================
// Interface : jmpz_pc_unit_if
// Brief     : Request/result bundle of jmpz_pc_unit; counter signals exist
//             only when JMPZ_STATS_EN is defined.
// Rev       : 1.0 - initial release
// ============================================================================
`default_nettype none

interface jmpz_pc_unit_if #(
  parameter int ADDR_W = 20,
  parameter int CNT_W  = 16
);

  logic              in_valid;
  logic [ADDR_W-1:0] pc;
  logic              zero_flag;
  logic [ADDR_W-1:0] jmp_address;
  logic [ADDR_W-1:0] new_pc;
  logic              out_valid;
  logic              taken;
`ifdef JMPZ_STATS_EN
  logic [CNT_W-1:0]  taken_cnt;
  logic [CNT_W-1:0]  ntaken_cnt;
`endif

  modport master (
    output in_valid, pc, zero_flag, jmp_address,
`ifdef JMPZ_STATS_EN
    input  taken_cnt, ntaken_cnt,
`endif
    input  new_pc, out_valid, taken
  );

  modport slave (
    input  in_valid, pc, zero_flag, jmp_address,
`ifdef JMPZ_STATS_EN
    output taken_cnt, ntaken_cnt,
`endif
    output new_pc, out_valid, taken
  );

endinterface : jmpz_pc_unit_if

`default_nettype wire

// File: rtl/jmpz_sat_counter.sv
// ============================================================================
// Module : jmpz_sat_counter
// Brief  : Event counter that saturates at its all-ones value.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jmpz_sat_counter #(
  parameter int CNT_W = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_inc,
  output logic      [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;
  logic             w_at_max;

  assign w_at_max = &r_count;
  assign o_count  = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && !w_at_max) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule : jmpz_sat_counter

`default_nettype wire

// File: rtl/jmpz_pc_unit.sv
// ============================================================================
// Module : jmpz_pc_unit
// Brief  : Registered next-PC select for JMPZ; optional taken/not-taken
//          statistics counters enabled by macro JMPZ_STATS_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jmpz_pc_unit
  import jmpz_pkg::*;
#(
  parameter int                ADDR_W   = DEFAULT_ADDR_W,
  parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(DEFAULT_PC_STEP),
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
  parameter int                CNT_W    = DEFAULT_CNT_W
) (
  input  wire logic     clk,
  input  wire logic     rst,
  jmpz_pc_unit_if.slave bus
);

  logic [ADDR_W-1:0] w_seq_pc;
  logic [ADDR_W-1:0] w_next_pc;
  logic [ADDR_W-1:0] r_new_pc;
  logic              r_out_valid;
  logic              r_taken;

  // Sum is truncated to ADDR_W, so the sequential PC wraps silently.
  assign w_seq_pc  = bus.pc + PC_STEP;
  assign w_next_pc = bus.zero_flag ? bus.jmp_address : w_seq_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_new_pc    <= RESET_PC;
      r_out_valid <= 1'b0;
      r_taken     <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_new_pc <= w_next_pc;
        r_taken  <= bus.zero_flag;
      end
    end
  end

  assign bus.new_pc    = r_new_pc;
  assign bus.out_valid = r_out_valid;
  assign bus.taken     = r_taken;

`ifdef JMPZ_STATS_EN
  logic w_inc_taken;
  logic w_inc_ntaken;

  assign w_inc_taken  = bus.in_valid &  bus.zero_flag;
  assign w_inc_ntaken = bus.in_valid & ~bus.zero_flag;

  jmpz_sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_inc_taken),
    .o_count (bus.taken_cnt)
  );

  jmpz_sat_counter #(.CNT_W(CNT_W)) u_ntaken_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_inc_ntaken),
    .o_count (bus.ntaken_cnt)
  );
`endif

endmodule : jmpz_pc_unit

`default_nettype wire

// File: tb/tb_jmpz_pc_unit.sv
// ============================================================================
// Module : tb_jmpz_pc_unit
// Brief  : Directed self-checking bench for jmpz_pc_unit (JMPZ_STATS_EN optional).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jmpz_pc_unit;

  localparam int ADDR_W = 20;
  localparam int CNT_W  = 2;

  logic clk;
  logic rst;

  int n_tests;
  int n_fail;

  jmpz_pc_unit_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  jmpz_pc_unit #(
    .ADDR_W   (ADDR_W),
    .PC_STEP  (20'h00001),
    .RESET_PC (20'h00000),
    .CNT_W    (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [ADDR_W-1:0] p, input logic z,
                       input logic [ADDR_W-1:0] j);
    @(negedge clk);
    bus.in_valid    = v;
    bus.pc          = p;
    bus.zero_flag   = z;
    bus.jmp_address = j;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [ADDR_W-1:0] pc_e,
                           input logic v_e, input logic t_e);
    check({tag, ".new_pc"},    32'(bus.new_pc),    32'(pc_e));
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(v_e));
    check({tag, ".taken"},     32'(bus.taken),     32'(t_e));
  endtask

  initial begin
    n_tests         = 0;
    n_fail          = 0;
    rst             = 1'b0;
    bus.in_valid    = 1'b0;
    bus.pc          = '0;
    bus.zero_flag   = 1'b0;
    bus.jmp_address = '0;

    // Reset takes effect without any clock edge
    #2 rst = 1'b1;
    #1 check_out("reset", 20'h00000, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    drive(1'b1, 20'h00000, 1'b1, 20'hABCDE); step();
    check_out("taken", 20'hABCDE, 1'b1, 1'b1);

    drive(1'b1, 20'h00000, 1'b0, 20'hABCDE); step();
    check_out("ntaken", 20'h00001, 1'b1, 1'b0);

    drive(1'b1, 20'hFFFFF, 1'b0, 20'h55555); step();
    check_out("wrap", 20'h00000, 1'b1, 1'b0);

    // Idle cycles: flag and target toggle but must be ignored
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 20'h11111, i[0], 20'h77777); step();
      check_out($sformatf("idle%0d", i), 20'h00000, 1'b0, 1'b0);
    end

    drive(1'b1, 20'h12345, 1'b1, 20'h12345); step();
    check_out("self_jmp", 20'h12345, 1'b1, 1'b1);

    // Back-to-back requests, one result per cycle
    drive(1'b1, 20'h00010, 1'b0, 20'h00F00); step();
    check_out("b2b0", 20'h00011, 1'b1, 1'b0);
    drive(1'b1, 20'h00011, 1'b1, 20'h00F00); step();
    check_out("b2b1", 20'h00F00, 1'b1, 1'b1);
    drive(1'b1, 20'h7FFFF, 1'b0, 20'h00F00); step();
    check_out("b2b2", 20'h80000, 1'b1, 1'b0);
    drive(1'b0, 20'h7FFFF, 1'b1, 20'h00F00); step();
    check_out("b2b_end", 20'h80000, 1'b0, 1'b0);

    // Reset pulsed between edges while requests stream every cycle
    drive(1'b1, 20'h00100, 1'b1, 20'h0BEEF); step();
    check_out("mid_pre", 20'h0BEEF, 1'b1, 1'b1);
    #1 rst = 1'b1;
    #1 check_out("mid_rst", 20'h00000, 1'b0, 1'b0);
    rst = 1'b0;
    drive(1'b1, 20'h00200, 1'b0, 20'h00ABC); step();
    check_out("mid_resume", 20'h00201, 1'b1, 1'b0);

    // Request pending while reset is held across the edge is dropped
    drive(1'b1, 20'h00300, 1'b1, 20'h00DDD);
    rst = 1'b1;
    step();
    check_out("drop", 20'h00000, 1'b0, 1'b0);
    drive(1'b1, 20'h00300, 1'b1, 20'h00DDD);
    rst = 1'b0;
    step();
    check_out("after_drop", 20'h00DDD, 1'b1, 1'b1);

`ifdef JMPZ_STATS_EN
    drive(1'b0, 20'h0, 1'b0, 20'h0);
    rst = 1'b1;
    #1 check("cnt_rst_t", 32'(bus.taken_cnt), 32'd0);
    check("cnt_rst_n", 32'(bus.ntaken_cnt), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 20'h00040, 1'b1, 20'h00999); step();
    end
    drive(1'b1, 20'h00040, 1'b0, 20'h00999); step();
    drive(1'b0, 20'h00040, 1'b1, 20'h00999); step();
    check("cnt_taken_sat", 32'(bus.taken_cnt), 32'd3);
    check("cnt_ntaken", 32'(bus.ntaken_cnt), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule : tb_jmpz_pc_unit

`default_nettype wire
